// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit core control unit: opcodes, FSM state
// encodings, instruction field positions and small decode helpers.
package cpu_pkg;

  // Opcodes, ir[15:13]; doubles as the ALU function code.
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_ADDI = 3'b100;
  localparam logic [2:0] OP_LW   = 3'b101;
  localparam logic [2:0] OP_SW   = 3'b110;
  localparam logic [2:0] OP_BEQ  = 3'b111;

  // Control FSM states.
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  // Instruction field bit positions.
  localparam int OP_HI  = 15;
  localparam int OP_LO  = 13;
  localparam int RA_HI  = 12;
  localparam int RA_LO  = 10;
  localparam int RB_HI  = 9;
  localparam int RB_LO  = 7;
  localparam int RD_HI  = 6;
  localparam int RD_LO  = 4;
  localparam int IMM_HI = 6;

  // Opcodes with the MSB set use the immediate format.
  function automatic logic is_itype(input logic [2:0] op);
    return op[2];
  endfunction

  // addi, lw and sw feed the immediate into ALU operand B.
  function automatic logic uses_imm(input logic [2:0] op);
    return (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control unit: fetches over the imem handshake, decodes the
// instruction register, sequences dmem accesses and owns the PC.
module cpu_ctrl_fsm
  import cpu_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic [2:0]  rf_ra_addr,
  output logic [2:0]  rf_rb_addr,
  output logic [2:0]  rf_wr_addr,
  output logic        rf_we,
  output logic        wb_sel,
  output logic [2:0]  alufn,
  output logic        alu_b_sel,
  output logic [7:0]  imm_out,
  input  logic        alubeq,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        mdr_load,
  output logic        instr_done,
  output logic [7:0]  pc
);

  logic [2:0]  state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic        pend_q, pend_d;   // fetch request issued and not yet acked
  logic [2:0]  op_s;
  logic [7:0]  imm_s;
  logic        fetch_req_s;

  assign op_s  = ir_q[OP_HI:OP_LO];
  assign imm_s = {ir_q[IMM_HI], ir_q[IMM_HI:0]};

  // A pending fetch stays requested even if run drops before the ack.
  assign fetch_req_s = (state_q == S_FETCH) && (run || pend_q);

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign imm_out    = imm_s;
  assign rf_ra_addr = ir_q[RA_HI:RA_LO];
  assign rf_rb_addr = ir_q[RB_HI:RB_LO];
  assign rf_wr_addr = is_itype(op_s) ? ir_q[RB_HI:RB_LO] : ir_q[RD_HI:RD_LO];

  // State, PC, IR and fetch-pending registers; reset drops everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 16'h0000;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      pend_q  <= pend_d;
    end
  end

  // Next-state, IR capture and PC update.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    pend_d  = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (fetch_req_s && imem_ack) begin
          ir_d    = imem_data;
          state_d = S_DECODE;
        end else begin
          pend_d = fetch_req_s;
        end
      end
      S_DECODE: begin
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (op_s == OP_BEQ) begin
          pc_d    = pc_q + 8'd1 + (alubeq ? imm_s : 8'd0);
          state_d = S_FETCH;
        end else if ((op_s == OP_LW) || (op_s == OP_SW)) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (dmem_ack) begin
          if (op_s == OP_SW) begin
            pc_d    = pc_q + 8'd1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else begin
          state_d = S_MEM;
        end
      end
      S_WB: begin
        pc_d    = pc_q + 8'd1;
        state_d = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Control outputs decoded from the current state; ALU controls are held
  // from EXEC through MEM/WB so the address and result stay stable.
  always_comb begin
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    rf_we      = 1'b0;
    wb_sel     = 1'b0;
    mdr_load   = 1'b0;
    instr_done = 1'b0;
    alufn      = 3'b000;
    alu_b_sel  = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = fetch_req_s;
      end
      S_EXEC: begin
        alufn      = op_s;
        alu_b_sel  = uses_imm(op_s);
        instr_done = (op_s == OP_BEQ);
      end
      S_MEM: begin
        alufn      = op_s;
        alu_b_sel  = uses_imm(op_s);
        dmem_req   = 1'b1;
        dmem_we    = (op_s == OP_SW);
        mdr_load   = dmem_ack && (op_s == OP_LW);
        instr_done = dmem_ack && (op_s == OP_SW);
      end
      S_WB: begin
        alufn      = op_s;
        alu_b_sel  = uses_imm(op_s);
        rf_we      = 1'b1;
        wb_sel     = (op_s == OP_LW);
        instr_done = 1'b1;
      end
      default: begin
        imem_req = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Self-checking bench for cpu_ctrl_fsm: per-cycle expectations are queued
// when an instruction is issued and compared as the DUT steps through it.
module tb_cpu_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst, run, imem_req, imem_ack, rf_we, wb_sel, alu_b_sel, alubeq;
  logic        dmem_req, dmem_we, dmem_ack, mdr_load, instr_done;
  logic [7:0]  imem_addr, imm_out, pc;
  logic [15:0] imem_data;
  logic [2:0]  rf_ra_addr, rf_rb_addr, rf_wr_addr, alufn;

  cpu_ctrl_fsm #(.RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .rf_ra_addr(rf_ra_addr), .rf_rb_addr(rf_rb_addr), .rf_wr_addr(rf_wr_addr),
    .rf_we(rf_we), .wb_sel(wb_sel), .alufn(alufn), .alu_b_sel(alu_b_sel),
    .imm_out(imm_out), .alubeq(alubeq), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_ack(dmem_ack), .mdr_load(mdr_load), .instr_done(instr_done), .pc(pc)
  );

  always #5 clk = ~clk;

  // ph: 0 fetch, 1 decode, 2 exec, 3 mem, 4 write-back
  typedef struct {
    logic [2:0] ph;
    logic       iack;
    logic       dack;
    logic [7:0] ctl;
    logic [7:0] mask;
  } exp_t;

  exp_t       sb_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] pc_model;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (pc_model %h)", tag, obs, exp_v, pc_model);
    end
  endtask

  function automatic logic [7:0] ctl_obs();
    return {imem_req, dmem_req, dmem_we, rf_we, mdr_load, instr_done, wb_sel, alu_b_sel};
  endfunction

  task automatic push(input logic [2:0] ph, input logic iack, input logic dack,
                      input logic [7:0] ctl, input logic [7:0] mask);
    exp_t e;
    e.ph = ph; e.iack = iack; e.dack = dack; e.ctl = ctl; e.mask = mask;
    sb_q.push_back(e);
  endtask

  // Issue one instruction with iw imem wait cycles and dw dmem wait cycles.
  task automatic run_instr(input logic [15:0] ins, input int iw, input int dw, input logic beq_i);
    logic [2:0] op;
    logic [7:0] imm;
    logic       bsel, is_lw, is_sw, is_beq, first;
    exp_t       e;
    op     = ins[15:13];
    imm    = {ins[6], ins[6:0]};
    is_lw  = (op == 3'b101);
    is_sw  = (op == 3'b110);
    is_beq = (op == 3'b111);
    bsel   = (op == 3'b100) || is_lw || is_sw;
    for (int k = 0; k <= iw; k++) push(3'd0, (k == iw), 1'b0, 8'h80, 8'hFF);
    push(3'd1, 1'b0, 1'b0, 8'h00, 8'hFF);
    push(3'd2, 1'b0, 1'b0, {5'b00000, is_beq, 1'b0, bsel}, 8'hFF);
    if (is_lw || is_sw) begin
      for (int k = 0; k <= dw; k++)
        push(3'd3, 1'b0, (k == dw),
             {1'b0, 1'b1, is_sw, 1'b0, is_lw && (k == dw), is_sw && (k == dw), 1'b0, bsel}, 8'hFF);
    end
    if (!is_beq && !is_sw) push(3'd4, 1'b0, 1'b0, {5'b00010, 1'b1, is_lw, 1'b0}, 8'hFE);
    first = 1'b1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      @(negedge clk);
      run = first;
      first = 1'b0;
      imem_data = ins;
      imem_ack = e.iack;
      dmem_ack = e.dack;
      alubeq = beq_i;
      #1;
      chk("ctl", 16'(ctl_obs() & e.mask), 16'(e.ctl & e.mask));
      case (e.ph)
        3'd0: begin
          chk("imem_addr", 16'(imem_addr), 16'(pc_model));
          chk("pc", 16'(pc), 16'(pc_model));
        end
        3'd1: begin
          chk("ra", 16'(rf_ra_addr), 16'(ins[12:10]));
          chk("rb", 16'(rf_rb_addr), 16'(ins[9:7]));
        end
        3'd2, 3'd3: begin
          chk("alufn", 16'(alufn), 16'(op));
          chk("imm", 16'(imm_out), 16'(imm));
        end
        3'd4: chk("wraddr", 16'(rf_wr_addr), 16'(op[2] ? ins[9:7] : ins[6:4]));
        default: chk("phase", 16'(e.ph), 16'd0);
      endcase
    end
    if (is_beq && beq_i) pc_model = pc_model + 8'd1 + imm;
    else                 pc_model = pc_model + 8'd1;
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    imem_data = 16'h0000; alubeq = 1'b0; pc_model = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ctl", 16'(ctl_obs()), 16'd0);
    chk("rst_pc", 16'(pc), 16'h0000);
    chk("rst_alufn", 16'(alufn), 16'd0);
    @(negedge clk);
    rst = 1'b0;

    run_instr(16'h0530, 0, 0, 1'b0);  // add  0x00 -> 0x01
    run_instr(16'hA505, 0, 3, 1'b0);  // lw, 3 dmem waits
    run_instr(16'hC505, 2, 0, 1'b0);  // sw, 2 imem waits with run dropped
    run_instr(16'h2530, 1, 0, 1'b0);  // sub
    run_instr(16'h4530, 0, 0, 1'b0);  // and
    run_instr(16'h6530, 0, 0, 1'b0);  // or
    run_instr(16'h8283, 0, 0, 1'b0);  // addi -> 0x07
    run_instr(16'hE508, 0, 0, 1'b1);  // beq taken +8 -> 0x10
    run_instr(16'hE57E, 0, 0, 1'b1);  // beq taken -2 -> 0x0F
    run_instr(16'hE57E, 0, 0, 1'b0);  // not taken -> 0x10
    run_instr(16'hE57E, 0, 0, 1'b0);  // not taken -> 0x11
    run_instr(16'hE56D, 0, 0, 1'b1);  // taken -19 -> 0xFF
    run_instr(16'h0530, 0, 0, 1'b0);  // add wraps -> 0x00
    run_instr(16'hE57E, 0, 0, 1'b1);  // beq taken wraps -> 0xFF
    @(negedge clk);
    #1;
    chk("pc_wrap", 16'(pc), 16'(pc_model));

    // Reset while a load is waiting in MEM.
    run = 1'b1; imem_data = 16'hA505; imem_ack = 1'b1;
    #1;
    chk("mr_fetch", 16'(imem_req), 16'd1);
    @(negedge clk); run = 1'b0; imem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("mr_dreq", 16'(dmem_req), 16'd1);
    #1 rst = 1'b1;
    #1;
    chk("mr_rst_ctl", 16'(ctl_obs()), 16'd0);
    chk("mr_rst_pc", 16'(pc), 16'h0000);
    @(negedge clk); dmem_ack = 1'b1;
    #1;
    chk("mr_late_ack", 16'(ctl_obs()), 16'd0);
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk("idle_ctl", 16'(ctl_obs()), 16'd0);
      chk("idle_pc", 16'(pc), 16'h0000);
    end
    dmem_ack = 1'b0;
    pc_model = 8'h00;
    run_instr(16'h0530, 0, 0, 1'b0);
    @(negedge clk);
    run = 1'b0;
    #1;
    chk("final_pc", 16'(pc), 16'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl_fsm.md
Name: cpu_ctrl_fsm

Overview:
- Multi-cycle control unit for the 8-bit core.
- Fetches 16-bit instructions over an instruction-memory handshake, decodes them and drives the ALU function code, operand-B select and register-file controls.
- Sequences data-memory accesses over a req/ack handshake and owns the PC, including beq resolution from the ALU's alubeq flag.
- Sits between imem/dmem, the register file and the ALU; it contains no datapath arithmetic except PC update.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  when low, no new fetch is started.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  8  fetch address, equal to pc.
- imem_ack  in  1  fetch data valid this cycle.
- imem_data  in  16  instruction word.
- rf_ra_addr  out  3  register read port A, equal to ir[12:10].
- rf_rb_addr  out  3  register read port B, equal to ir[9:7].
- rf_wr_addr  out  3  write address: ir[6:4] for R-type, ir[9:7] otherwise.
- rf_we  out  1  register write enable.
- wb_sel  out  1  write-back source: 0 = ALU, 1 = memory data register.
- alufn  out  3  ALU function code.
- alu_b_sel  out  1  ALU operand B: 0 = register B, 1 = imm_out.
- imm_out  out  8  sign-extended ir[6:0].
- alubeq  in  1  ALU equality flag.
- dmem_req  out  1  data-memory request.
- dmem_we  out  1  data-memory write; valid only while dmem_req is high.
- dmem_ack  in  1  data-memory access complete.
- mdr_load  out  1  load the memory data register.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- pc  out  8  current program counter.

Behaviour:
- Clock and reset are fixed: one clock, clk; rst is asynchronous and active-high.
- On rst: state FETCH, pc=RESET_PC, ir=16'h0000.
- All enables/requests are 0 on rst: imem_req, dmem_req, dmem_we, rf_we, mdr_load, instr_done.
- On rst: alufn=3'b000, alu_b_sel=0, wb_sel=0.
- Reset mid-operation drops all requests asynchronously. An ack arriving after that is ignored.
- Opcodes are ir[15:13]:
  - 000 add, 001 sub, 010 and, 011 or: R-type.
  - 100 addi, 101 lw, 110 sw, 111 beq: I-type.
- State FETCH:
  - imem_req = run. imem_addr = pc.
  - On a cycle with imem_req && imem_ack: ir <= imem_data, go to DECODE.
  - imem_req and imem_addr stay stable until ack. ack may arrive in the first req cycle.
  - Acks with req low are ignored.
  - run going low while a request is pending does not withdraw the request; it only blocks the next fetch.
- State DECODE:
  - One cycle. rf addresses and imm_out are driven combinationally from ir in every state.
  - Go to EXEC.
- State EXEC:
  - One cycle. alufn = opcode. alu_b_sel = 1 for 100/101/110, else 0.
  - R-type or addi: go to WB.
  - lw or sw: go to MEM.
  - beq: sample alubeq at the clock edge.
    - Taken: pc <= pc + 1 + imm_out. Not taken: pc <= pc + 1.
    - All arithmetic is mod 256.
    - instr_done = 1, go to FETCH.
- State MEM:
  - alufn and alu_b_sel are held from EXEC so the address stays stable.
  - dmem_req = 1. dmem_we = (op == 110).
  - Held until dmem_ack, with no limit on wait cycles.
  - On ack, sw: pc <= pc + 1, instr_done = 1, go to FETCH.
  - On ack, lw: mdr_load = 1 in the ack cycle, go to WB.
- State WB:
  - rf_we = 1 for one cycle. wb_sel = (op == 101).
  - pc <= pc + 1, instr_done = 1, go to FETCH.
- Latency with zero-wait acks:
  - R-type/addi: 4 cycles. lw: 5. sw: 4. beq: 3.
  - Each wait cycle on imem or dmem adds one.
- PC wraps 8'hFF -> 8'h00, and branch targets wrap the same way.
- Only one request (imem or dmem) is ever high at a time. rf_we is never high outside WB.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode/alufn constants: OP_ADD..OP_BEQ = 3'b000..3'b111.
  - state enum: FETCH, DECODE, EXEC, MEM, WB.
  - instruction field bit positions.
  - a function is_itype(op).
- No sub-module needed. The FSM, IR and PC registers live in one module; decode is combinational inside it.

Test Plan:
- Reset, run=1, imem_data=16'h0530 (add r3=r1+r2), ack immediate -> EXEC alufn=000, alu_b_sel=0; cycle 4 rf_we=1, rf_wr_addr=3, wb_sel=0; pc 0->1, instr_done pulse.
- lw 16'hA505 (r2=mem[r1+5]), dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0, alufn=101, alu_b_sel=1, imm_out=8'h05 stable throughout; mdr_load in ack cycle; then rf_we with rf_wr_addr=2, wb_sel=1.
- beq 16'hE57E (imm=-2) at pc=8'h10: alubeq=1 -> pc=8'h0F; alubeq=0 -> pc=8'h11; rf_we and dmem_req stay 0.
- sw 16'hC505 -> dmem_req=1, dmem_we=1, rf_we never asserted, pc+1 on ack; imem wait of 2 cycles -> imem_addr held stable.
- Wrap: add at pc=8'hFF -> pc=8'h00; beq taken imm=-2 at pc=8'h00 -> pc=8'hFF.
- Assert rst mid-MEM with dmem_req high -> dmem_req=0 immediately, pc=RESET_PC, state FETCH; a late dmem_ack after reset has no effect. With run=0 after reset, imem_req stays 0.
